csr_trap_unit: RTL and testbench

Machine-mode trap and CSR unit on the consuming end of the `cpu_control_signals` bundle: it takes the `IntCause` and `MRet` decisions issued by the control unit, plus an external interrupt line. It updates the machine CSRs (`mstatus`, `mie`, `mtvec`, `mepc`, `mcause`, `mip`) and issues a one-cycle PC redirect to the fetch stage. It sits beside the datapath's PC logic and owns all trap sequencing.

---
 rtl/trap_pkg.sv | 51 +++++
 rtl/irq_sync.sv | 25 ++
 rtl/csr_trap_unit.sv | 147 ++++++++++++++
 tb/tb_csr_trap_unit.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trap_pkg.sv
// Shared constants and types for the machine-mode trap/CSR unit.
// Holds CSR addresses, mcause codes, mstatus bit positions and the FSM and IntCause enums.
package trap_pkg;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MIE     = 12'h304;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MIP     = 12'h344;

    localparam logic [31:0] MCAUSE_ILLEGAL = 32'd2;
    localparam logic [31:0] MCAUSE_ECALL   = 32'd11;
    localparam logic [31:0] MCAUSE_EBREAK  = 32'd3;
    localparam logic [31:0] MCAUSE_MEI     = 32'h8000_000B;

    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;
    localparam int MIE_MEIE     = 11;
    localparam int MIP_MEIP     = 11;

    localparam logic [31:0] IRQ_VEC_OFFSET = 32'd44;

    typedef enum logic [1:0] {
        IC_NONE    = 2'b00,
        IC_ILLEGAL = 2'b01,
        IC_ECALL   = 2'b10,
        IC_EBREAK  = 2'b11
    } int_cause_e;

    typedef enum logic {
        RUN      = 1'b0,
        REDIRECT = 1'b1
    } trap_state_e;

    // Datapath slice of the control bundle; only these fields matter here.
    typedef struct packed {
        logic [1:0] IntCause;
        logic       MRet;
    } datapath_ctrl_t;

    function automatic logic [31:0] cause_code(input int_cause_e c);
        case (c)
            IC_ILLEGAL: return MCAUSE_ILLEGAL;
            IC_ECALL:   return MCAUSE_ECALL;
            IC_EBREAK:  return MCAUSE_EBREAK;
            default:    return 32'd0;
        endcase
    endfunction

endpackage

// File: rtl/irq_sync.sv
// Two-flop synchronizer for an asynchronous level input.
// Latency: 2 clk edges; no backpressure.
module irq_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/csr_trap_unit.sv
// Machine-mode trap sequencing and CSRs; TRAP_VECTORED_EN enables vectored interrupt mode in mtvec.
// Latency: event at edge N gives a one-cycle redirect pulse in cycle N+1; no backpressure, fetch must take it.
module csr_trap_unit
    import trap_pkg::*;
#(
    parameter int               XLEN        = 32,
    parameter logic [XLEN-1:0]  MTVEC_RESET = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  datapath_ctrl_t      ctrl,
    input  logic                inst_valid,
    input  logic [XLEN-1:0]     pc,
    input  logic                irq_ext,
    input  logic                csr_we,
    input  logic [11:0]         csr_addr,
    input  logic [XLEN-1:0]     csr_wdata,
    output logic [XLEN-1:0]     csr_rdata,
    output logic                redirect_valid,
    output logic [XLEN-1:0]     redirect_pc
);

    trap_state_e     state_q, state_d;
    logic            mie_bit_q, mie_bit_d;
    logic            mpie_q, mpie_d;
    logic            meie_q, meie_d;
    logic [XLEN-1:0] mtvec_q, mtvec_d;
    logic [XLEN-1:0] mepc_q, mepc_d;
    logic [XLEN-1:0] mcause_q, mcause_d;
    logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;

    logic            meip_sync;
    logic            irq_pend;
    logic            take_exc;
    logic            take_mret;
    logic            vec_mode;
    logic [XLEN-1:0] trap_base;
    logic [XLEN-1:0] mtvec_wmask;
    logic [XLEN-1:0] mstatus_rd;
    logic            unused_pc_lsb;

    irq_sync u_irq_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (irq_ext),
        .q_o   (meip_sync)
    );

`ifdef TRAP_VECTORED_EN
    assign vec_mode    = mtvec_q[0];
    assign mtvec_wmask = {{(XLEN-2){1'b1}}, 2'b01};
`else
    assign vec_mode    = 1'b0;
    assign mtvec_wmask = {{(XLEN-2){1'b1}}, 2'b00};
`endif

    assign irq_pend      = meip_sync & meie_q & mie_bit_q;
    assign take_exc      = inst_valid && (ctrl.IntCause != IC_NONE);
    assign take_mret     = inst_valid && ctrl.MRet;
    assign trap_base     = {mtvec_q[XLEN-1:2], 2'b00};
    assign unused_pc_lsb = ^pc[1:0];

    always_comb begin
        state_d       = RUN;
        mie_bit_d     = mie_bit_q;
        mpie_d        = mpie_q;
        meie_d        = meie_q;
        mtvec_d       = mtvec_q;
        mepc_d        = mepc_q;
        mcause_d      = mcause_q;
        redirect_pc_d = redirect_pc_q;
        // The REDIRECT cycle's instruction is being flushed, so nothing is sampled.
        if (state_q == RUN) begin
            if (take_exc || irq_pend) begin
                state_d       = REDIRECT;
                mepc_d        = {pc[XLEN-1:2], 2'b00};
                mcause_d      = take_exc ? cause_code(int_cause_e'(ctrl.IntCause)) : MCAUSE_MEI;
                mpie_d        = mie_bit_q;
                mie_bit_d     = 1'b0;
                redirect_pc_d = (!take_exc && vec_mode) ? trap_base + IRQ_VEC_OFFSET : trap_base;
            end else if (take_mret) begin
                state_d       = REDIRECT;
                mie_bit_d     = mpie_q;
                mpie_d        = 1'b1;
                redirect_pc_d = mepc_q;
            end else if (inst_valid && csr_we) begin
                case (csr_addr)
                    CSR_MSTATUS: begin
                        mie_bit_d = csr_wdata[MSTATUS_MIE];
                        mpie_d    = csr_wdata[MSTATUS_MPIE];
                    end
                    CSR_MIE:    meie_d   = csr_wdata[MIE_MEIE];
                    CSR_MTVEC:  mtvec_d  = csr_wdata & mtvec_wmask;
                    CSR_MEPC:   mepc_d   = {csr_wdata[XLEN-1:2], 2'b00};
                    CSR_MCAUSE: mcause_d = csr_wdata;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= RUN;
            mie_bit_q     <= 1'b0;
            mpie_q        <= 1'b0;
            meie_q        <= 1'b0;
            mtvec_q       <= MTVEC_RESET & mtvec_wmask;
            mepc_q        <= '0;
            mcause_q      <= '0;
            redirect_pc_q <= '0;
        end else begin
            state_q       <= state_d;
            mie_bit_q     <= mie_bit_d;
            mpie_q        <= mpie_d;
            meie_q        <= meie_d;
            mtvec_q       <= mtvec_d;
            mepc_q        <= mepc_d;
            mcause_q      <= mcause_d;
            redirect_pc_q <= redirect_pc_d;
        end
    end

    always_comb begin
        mstatus_rd               = '0;
        mstatus_rd[12:11]        = 2'b11;
        mstatus_rd[MSTATUS_MPIE] = mpie_q;
        mstatus_rd[MSTATUS_MIE]  = mie_bit_q;
    end

    always_comb begin
        csr_rdata = '0;
        case (csr_addr)
            CSR_MSTATUS: csr_rdata = mstatus_rd;
            CSR_MIE:     csr_rdata[MIE_MEIE] = meie_q;
            CSR_MTVEC:   csr_rdata = mtvec_q;
            CSR_MEPC:    csr_rdata = mepc_q;
            CSR_MCAUSE:  csr_rdata = mcause_q;
            CSR_MIP:     csr_rdata[MIP_MEIP] = meip_sync;
            default:     csr_rdata = '0;
        endcase
    end

    assign redirect_valid = (state_q == REDIRECT);
    assign redirect_pc    = redirect_pc_q;

endmodule

// File: tb/tb_csr_trap_unit.sv
// Directed scenarios plus randomized traffic checked against a cycle-level reference model.
`timescale 1ns/1ps
module tb_csr_trap_unit;
    import trap_pkg::*;

    logic           clk = 1'b0;
    logic           rst_n;
    datapath_ctrl_t ctrl;
    logic           inst_valid;
    logic [31:0]    pc;
    logic           irq_ext;
    logic           csr_we;
    logic [11:0]    csr_addr;
    logic [31:0]    csr_wdata;
    logic [31:0]    csr_rdata;
    logic           redirect_valid;
    logic [31:0]    redirect_pc;

    int checks = 0;
    int errors = 0;

    // Reference model: architectural CSR contents, synchronizer stages, pending redirect.
    bit          m_mie, m_mpie, m_meie, m_s1, m_s2, m_rv;
    logic [31:0] m_mtvec, m_mepc, m_mcause, m_rpc;

    csr_trap_unit #(.XLEN(32), .MTVEC_RESET(32'h0)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ctrl           (ctrl),
        .inst_valid     (inst_valid),
        .pc             (pc),
        .irq_ext        (irq_ext),
        .csr_we         (csr_we),
        .csr_addr       (csr_addr),
        .csr_wdata      (csr_wdata),
        .csr_rdata      (csr_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] m_read(input logic [11:0] a);
        case (a)
            12'h300: return 32'h1800 | (32'(m_mpie) << 7) | (32'(m_mie) << 3);
            12'h304: return 32'(m_meie) << 11;
            12'h305: return m_mtvec;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'h344: return 32'(m_s2) << 11;
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        m_mie = 0; m_mpie = 0; m_meie = 0; m_s1 = 0; m_s2 = 0; m_rv = 0;
        m_mtvec = 32'h0; m_mepc = 32'h0; m_mcause = 32'h0; m_rpc = 32'h0;
    endtask

    task automatic model_edge();
        bit          pend;
        logic [31:0] base;
        int          code;
        pend = m_s2 && m_meie && m_mie;
        base = m_mtvec & ~32'h3;
        if (m_rv) begin
            m_rv = 0;
        end else begin
            m_rv = 0;
            if (inst_valid && ctrl.IntCause != 2'b00) begin
                code = (ctrl.IntCause == 2'b01) ? 2 : (ctrl.IntCause == 2'b10) ? 11 : 3;
                m_mepc = pc & ~32'h3; m_mcause = 32'(code);
                m_mpie = m_mie; m_mie = 0; m_rv = 1; m_rpc = base;
            end else if (pend) begin
                m_mepc = pc & ~32'h3; m_mcause = 32'h8000_000B;
                m_mpie = m_mie; m_mie = 0; m_rv = 1;
                m_rpc = m_mtvec[0] ? base + 32'd44 : base;
            end else if (inst_valid && ctrl.MRet) begin
                m_mie = m_mpie; m_mpie = 1; m_rv = 1; m_rpc = m_mepc;
            end else if (inst_valid && csr_we) begin
                case (csr_addr)
                    12'h300: begin m_mie = csr_wdata[3]; m_mpie = csr_wdata[7]; end
                    12'h304: m_meie = csr_wdata[11];
`ifdef TRAP_VECTORED_EN
                    12'h305: m_mtvec = csr_wdata & 32'hFFFF_FFFD;
`else
                    12'h305: m_mtvec = csr_wdata & 32'hFFFF_FFFC;
`endif
                    12'h341: m_mepc = csr_wdata & 32'hFFFF_FFFC;
                    12'h342: m_mcause = csr_wdata;
                    default: ;
                endcase
            end
        end
        m_s2 = m_s1;
        m_s1 = irq_ext;
    endtask

    task automatic step();
        @(posedge clk);
        if (rst_n) model_edge();
        #1;
    endtask

    task automatic idle();
        inst_valid = 0; csr_we = 0; ctrl = '0;
    endtask

    task automatic csr_write(input logic [11:0] a, input logic [31:0] d);
        inst_valid = 1; csr_we = 1; ctrl = '0; csr_addr = a; csr_wdata = d;
        step();
        idle();
    endtask

    task automatic do_reset();
        rst_n = 0; idle(); irq_ext = 0; pc = 32'h0; csr_addr = 12'h0; csr_wdata = 32'h0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
    endtask

    task automatic test_reset();
        rst_n = 0; idle(); irq_ext = 0; pc = 32'h0; csr_wdata = 32'h0;
        csr_addr = 12'h300; #1;
        checks++; if (csr_rdata !== 32'h1800) begin errors++; $display("FAIL reset_mstatus got=%h exp=%h", csr_rdata, 32'h1800); end
        checks++; if (redirect_valid !== 1'b0 || redirect_pc !== 32'h0) begin errors++; $display("FAIL reset_redirect got=%b/%h exp=0/0", redirect_valid, redirect_pc); end
        csr_addr = 12'h305; #1;
        checks++; if (csr_rdata !== 32'h0) begin errors++; $display("FAIL reset_mtvec got=%h exp=0", csr_rdata); end
        csr_addr = 12'h304; #1;
        checks++; if (csr_rdata !== 32'h0) begin errors++; $display("FAIL reset_mie got=%h exp=0", csr_rdata); end
        do_reset();
    endtask

    task automatic test_ecall();
        do_reset();
        csr_write(12'h305, 32'h100);
        csr_write(12'h300, 32'h8);
        inst_valid = 1; ctrl.IntCause = 2'b10; pc = 32'h40;
        step();
        checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h100) begin errors++; $display("FAIL ecall_redirect got=%b/%h exp=1/100", redirect_valid, redirect_pc); end
        idle();
        csr_addr = 12'h341; #1;
        checks++; if (csr_rdata !== 32'h40) begin errors++; $display("FAIL ecall_mepc got=%h exp=40", csr_rdata); end
        csr_addr = 12'h342; #1;
        checks++; if (csr_rdata !== 32'd11) begin errors++; $display("FAIL ecall_mcause got=%h exp=b", csr_rdata); end
        csr_addr = 12'h300; #1;
        checks++; if (csr_rdata !== 32'h1880) begin errors++; $display("FAIL ecall_mstatus got=%h exp=1880", csr_rdata); end
        step();
        checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL ecall_pulse_width got=%b exp=0", redirect_valid); end
    endtask

    task automatic test_mret();
        do_reset();
        csr_write(12'h300, 32'h80);
        csr_write(12'h341, 32'h44);
        inst_valid = 1; ctrl.MRet = 1; csr_we = 1; csr_addr = 12'h341; csr_wdata = 32'h99;
        step();
        checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h44) begin errors++; $display("FAIL mret_redirect got=%b/%h exp=1/44", redirect_valid, redirect_pc); end
        idle();
        csr_addr = 12'h300; #1;
        checks++; if (csr_rdata !== 32'h1888) begin errors++; $display("FAIL mret_mstatus got=%h exp=1888", csr_rdata); end
        csr_addr = 12'h341; #1;
        checks++; if (csr_rdata !== 32'h44) begin errors++; $display("FAIL mret_dropped_write got=%h exp=44", csr_rdata); end
    endtask

    task automatic test_irq();
        do_reset();
        csr_write(12'h305, 32'h200);
        csr_write(12'h304, 32'h800);
        csr_write(12'h300, 32'h8);
        pc = 32'h123; csr_addr = 12'h344;
        irq_ext = 1;
        step();
        checks++; if (redirect_valid !== 1'b0 || csr_rdata !== 32'h0) begin errors++; $display("FAIL irq_edge1 got=%b/%h exp=0/0", redirect_valid, csr_rdata); end
        step();
        checks++; if (redirect_valid !== 1'b0 || csr_rdata !== 32'h800) begin errors++; $display("FAIL irq_mip got=%b/%h exp=0/800", redirect_valid, csr_rdata); end
        step();
        checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h200) begin errors++; $display("FAIL irq_redirect got=%b/%h exp=1/200", redirect_valid, redirect_pc); end
        irq_ext = 0;
        csr_addr = 12'h342; #1;
        checks++; if (csr_rdata !== 32'h8000_000B) begin errors++; $display("FAIL irq_mcause got=%h exp=8000000b", csr_rdata); end
        csr_addr = 12'h341; #1;
        checks++; if (csr_rdata !== 32'h120) begin errors++; $display("FAIL irq_mepc got=%h exp=120", csr_rdata); end
        csr_addr = 12'h300; #1;
        checks++; if (csr_rdata !== 32'h1880) begin errors++; $display("FAIL irq_mstatus got=%h exp=1880", csr_rdata); end
    endtask

    task automatic test_priority();
        do_reset();
        csr_write(12'h304, 32'h800);
        irq_ext = 1;
        repeat (3) step();
        csr_write(12'h300, 32'h8);
        inst_valid = 1; ctrl.IntCause = 2'b01; csr_we = 1; csr_addr = 12'h304; csr_wdata = 32'h0; pc = 32'h88;
        step();
        checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h0) begin errors++; $display("FAIL prio_redirect got=%b/%h exp=1/0", redirect_valid, redirect_pc); end
        idle(); irq_ext = 0;
        csr_addr = 12'h342; #1;
        checks++; if (csr_rdata !== 32'd2) begin errors++; $display("FAIL prio_mcause got=%h exp=2", csr_rdata); end
        csr_addr = 12'h304; #1;
        checks++; if (csr_rdata !== 32'h800) begin errors++; $display("FAIL prio_mie got=%h exp=800", csr_rdata); end
        csr_addr = 12'h341; #1;
        checks++; if (csr_rdata !== 32'h88) begin errors++; $display("FAIL prio_mepc got=%h exp=88", csr_rdata); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        csr_write(12'h305, 32'h100);
        inst_valid = 1; ctrl.IntCause = 2'b10; pc = 32'h40;
        step();
        checks++; if (redirect_valid !== 1'b1) begin errors++; $display("FAIL blank_first got=%b exp=1", redirect_valid); end
        pc = 32'h80;
        step();
        checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL blank_second got=%b exp=0", redirect_valid); end
        idle();
        csr_addr = 12'h341; #1;
        checks++; if (csr_rdata !== 32'h40) begin errors++; $display("FAIL blank_mepc got=%h exp=40", csr_rdata); end
    endtask

    task automatic test_reset_mid_redirect();
        do_reset();
        csr_write(12'h305, 32'h100);
        inst_valid = 1; ctrl.IntCause = 2'b11; pc = 32'h60;
        step();
        checks++; if (redirect_valid !== 1'b1) begin errors++; $display("FAIL midrst_pre got=%b exp=1", redirect_valid); end
        rst_n = 0; idle(); model_reset();
        #1;
        checks++; if (redirect_valid !== 1'b0 || redirect_pc !== 32'h0) begin errors++; $display("FAIL midrst_redirect got=%b/%h exp=0/0", redirect_valid, redirect_pc); end
        csr_addr = 12'h342; #1;
        checks++; if (csr_rdata !== 32'h0) begin errors++; $display("FAIL midrst_mcause got=%h exp=0", csr_rdata); end
        do_reset();
    endtask

    task automatic test_vectored();
        int n;
        do_reset();
        csr_write(12'h305, 32'h201);
        csr_addr = 12'h305; #1;
`ifdef TRAP_VECTORED_EN
        checks++; if (csr_rdata !== 32'h201) begin errors++; $display("FAIL vec_mtvec got=%h exp=201", csr_rdata); end
`else
        checks++; if (csr_rdata !== 32'h200) begin errors++; $display("FAIL vec_mtvec got=%h exp=200", csr_rdata); end
`endif
        csr_write(12'h304, 32'h800);
        csr_write(12'h300, 32'h8);
        irq_ext = 1;
        n = 0;
        while (n < 10 && redirect_valid !== 1'b1) begin step(); n++; end
        checks++; if (redirect_valid !== 1'b1 || n != 3) begin errors++; $display("FAIL vec_latency got=%b after %0d edges exp=1 after 3", redirect_valid, n); end
`ifdef TRAP_VECTORED_EN
        checks++; if (redirect_pc !== 32'h22C) begin errors++; $display("FAIL vec_irq_pc got=%h exp=22c", redirect_pc); end
`else
        checks++; if (redirect_pc !== 32'h200) begin errors++; $display("FAIL vec_irq_pc got=%h exp=200", redirect_pc); end
`endif
        irq_ext = 0;
        step();
        inst_valid = 1; ctrl.IntCause = 2'b10; pc = 32'h10;
        step();
        checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h200) begin errors++; $display("FAIL vec_exc_pc got=%b/%h exp=1/200", redirect_valid, redirect_pc); end
        idle();
    endtask

    task automatic test_random();
        logic [11:0] addrs [8];
        addrs = '{12'h300, 12'h304, 12'h305, 12'h341, 12'h342, 12'h344, 12'h7C0, 12'h301};
        do_reset();
        for (int i = 0; i < 600; i++) begin
            inst_valid    = ($urandom_range(0, 3) != 0);
            ctrl.IntCause = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            ctrl.MRet     = ($urandom_range(0, 7) == 0);
            csr_we        = ($urandom_range(0, 1) == 1);
            csr_addr      = addrs[$urandom_range(0, 7)];
            csr_wdata     = $urandom();
            pc            = $urandom();
            if ($urandom_range(0, 15) == 0) irq_ext = ~irq_ext;
            step();
            checks++; if (redirect_valid !== m_rv) begin errors++; $display("FAIL rand_valid cyc=%0d got=%b exp=%b", i, redirect_valid, m_rv); end
            checks++; if (redirect_pc !== m_rpc) begin errors++; $display("FAIL rand_pc cyc=%0d got=%h exp=%h", i, redirect_pc, m_rpc); end
            checks++; if (csr_rdata !== m_read(csr_addr)) begin errors++; $display("FAIL rand_rdata cyc=%0d addr=%h got=%h exp=%h", i, csr_addr, csr_rdata, m_read(csr_addr)); end
        end
        idle(); irq_ext = 0;
    endtask

    initial begin
        test_reset();
        test_ecall();
        test_mret();
        test_irq();
        test_priority();
        test_back_to_back();
        test_reset_mid_redirect();
        test_vectored();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
